vmacc_seq: RTL and testbench

//  Sequencer for vector multiply-accumulate (vd = vs1*vs2 + vd) directly upstream of the vector MAC.

---
 rtl/vmacc_pkg.sv | 24 ++
 rtl/vmacc_seq_if.sv | 38 +++
 rtl/vmacc_seq.sv | 117 +++++++++++
 tb/tb_vmacc_seq.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/vmacc_pkg.sv
// Shared types and constants for the vector multiply-accumulate sequencer.
package vmacc_pkg;

  localparam int VL        = 8;
  localparam int SEW       = 32;
  localparam int ADDR_W    = 5;
  localparam int DATA_W    = VL * SEW;
  localparam int VMACC_LAT = 7;

  typedef enum logic [2:0] {
    IDLE,
    RD1,
    RD2,
    RD3,
    CAP,
    MAC1,
    MAC2,
    WB
  } state_t;

  typedef logic [ADDR_W-1:0] vaddr_t;
  typedef logic [DATA_W-1:0] vreg_t;

endpackage

// File: rtl/vmacc_seq_if.sv
// Request, register-file and MAC signals of the vmacc sequencer; master is the sequencer side.
interface vmacc_seq_if;
  import vmacc_pkg::*;

  logic   start;
  vaddr_t vs1_addr;
  vaddr_t vs2_addr;
  vaddr_t vd_addr;
  logic   busy;
  logic   done;

  logic   rf_rd_en;
  vaddr_t rf_rd_addr;
  vreg_t  rf_rd_data;
  logic   rf_wr_en;
  logic   rf_wr_ready;
  vaddr_t rf_wr_addr;
  vreg_t  rf_wr_data;

  vreg_t  mac_vector_a;
  vreg_t  mac_vector_b;
  vreg_t  mac_vd;
  logic   mac_valid;
  vreg_t  mac_result;

  modport master (
    input  start, vs1_addr, vs2_addr, vd_addr, rf_rd_data, rf_wr_ready, mac_result,
    output busy, done, rf_rd_en, rf_rd_addr, rf_wr_en, rf_wr_addr, rf_wr_data,
           mac_vector_a, mac_vector_b, mac_vd, mac_valid
  );

  modport slave (
    output start, vs1_addr, vs2_addr, vd_addr, rf_rd_data, rf_wr_ready, mac_result,
    input  busy, done, rf_rd_en, rf_rd_addr, rf_wr_en, rf_wr_addr, rf_wr_data,
           mac_vector_a, mac_vector_b, mac_vd, mac_valid
  );

endinterface

// File: rtl/vmacc_seq.sv
// vd = vs1*vs2 + vd sequencer: three RF reads, 2-cycle MAC window, write-back; done 7 cycles after start.
// Write-back holds in WB while rf_wr_ready is low; start is ignored unless IDLE.
module vmacc_seq
  import vmacc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  vmacc_seq_if.master bus
);

  state_t state;
  state_t state_nxt;

  vaddr_t vs1_q;
  vaddr_t vs2_q;
  vaddr_t vd_q;
  vreg_t  opa_q;
  vreg_t  opb_q;
  vreg_t  opc_q;
  vreg_t  res_q;

  logic   busy;
  logic   rd_en;
  vaddr_t rd_addr;
  logic   mac_valid;
  logic   wr_en;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RD1;
      RD1:     state_nxt = RD2;
      RD2:     state_nxt = RD3;
      RD3:     state_nxt = CAP;
      CAP:     state_nxt = MAC1;
      MAC1:    state_nxt = MAC2;
      MAC2:    state_nxt = WB;
      WB:      if (bus.rf_wr_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Write request is masked while reset is asserted so an aborted WB never commits.
  always_comb begin
    busy      = (state != IDLE);
    rd_en     = 1'b0;
    rd_addr   = '0;
    mac_valid = 1'b0;
    wr_en     = 1'b0;
    case (state)
      RD1: begin
        rd_en   = 1'b1;
        rd_addr = vs1_q;
      end
      RD2: begin
        rd_en   = 1'b1;
        rd_addr = vs2_q;
      end
      RD3: begin
        rd_en   = 1'b1;
        rd_addr = vd_q;
      end
      MAC1, MAC2: mac_valid = 1'b1;
      WB:         wr_en     = rst_n;
      default: ;
    endcase
  end

  // Read data lags its address by one cycle, so each operand lands one state later.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vs1_q <= '0;
      vs2_q <= '0;
      vd_q  <= '0;
      opa_q <= '0;
      opb_q <= '0;
      opc_q <= '0;
      res_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            vs1_q <= bus.vs1_addr;
            vs2_q <= bus.vs2_addr;
            vd_q  <= bus.vd_addr;
          end
        end
        RD2:  opa_q <= bus.rf_rd_data;
        RD3:  opb_q <= bus.rf_rd_data;
        CAP:  opc_q <= bus.rf_rd_data;
        MAC2: res_q <= bus.mac_result;
        default: ;
      endcase
    end
  end

  assign bus.busy         = busy;
  assign bus.done         = wr_en & bus.rf_wr_ready;
  assign bus.rf_rd_en     = rd_en;
  assign bus.rf_rd_addr   = rd_addr;
  assign bus.rf_wr_en     = wr_en;
  assign bus.rf_wr_addr   = vd_q;
  assign bus.rf_wr_data   = res_q;
  assign bus.mac_vector_a = opa_q;
  assign bus.mac_vector_b = opb_q;
  assign bus.mac_vd       = opc_q;
  assign bus.mac_valid    = mac_valid;

endmodule

// File: tb/tb_vmacc_seq.sv
// Randomized and directed bench for vmacc_seq with register-file and MAC models and a write-back scoreboard.
module tb_vmacc_seq;
  import vmacc_pkg::*;

  typedef struct {
    vaddr_t addr;
    vreg_t  data;
    int     cyc;
  } exp_t;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  int    cyc = 0;
  int    vectors = 0;
  int    miscompares = 0;
  exp_t  sbq[$];
  exp_t  mon_e;
  vreg_t mem[32];
  vreg_t ma, mb, mv;

  vmacc_seq_if bus();

  vmacc_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Register file: synchronous read, one-cycle latency.
  always @(posedge clk) if (bus.rf_rd_en) bus.rf_rd_data <= mem[bus.rf_rd_addr];

  // MAC: registers operands while valid, result only while valid.
  always @(posedge clk) begin
    if (bus.mac_valid) begin
      ma <= bus.mac_vector_a;
      mb <= bus.mac_vector_b;
      mv <= bus.mac_vd;
    end
  end

  always_comb begin
    bus.mac_result = '0;
    if (bus.mac_valid)
      for (int i = 0; i < VL; i++)
        bus.mac_result[i*SEW +: SEW] = {16'b0, ma[i*SEW +: 16]} * {16'b0, mb[i*SEW +: 16]} + mv[i*SEW +: SEW];
  end

  function automatic vreg_t ref_vmacc(input vreg_t a, input vreg_t b, input vreg_t c);
    vreg_t  r;
    longint p;
    r = '0;
    for (int i = 0; i < VL; i++) begin
      p = longint'(a[i*SEW +: 16]) * longint'(b[i*SEW +: 16]) + longint'(c[i*SEW +: SEW]);
      r[i*SEW +: SEW] = p[31:0];
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %h want %h", nm, cyc, act, exp);
    end
  endtask

  task automatic rand_reg(input int r);
    for (int i = 0; i < VL; i++) mem[r][i*SEW +: SEW] = $urandom;
  endtask

  always @(negedge clk) begin
    if (bus.rf_wr_en && bus.rf_wr_ready) begin
      if (sbq.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write at cycle %0d: got write to R%0d, want none", cyc, bus.rf_wr_addr);
      end else begin
        mon_e = sbq.pop_front();
        chk("wb_addr", bus.rf_wr_addr, mon_e.addr);
        chk("wb_data", bus.rf_wr_data, mon_e.data);
        chk("done_cycle", cyc, mon_e.cyc);
        chk("done_on_accept", bus.done, 1);
      end
    end else if (bus.done) begin
      vectors++;
      miscompares++;
      $display("FAIL spurious_done at cycle %0d: got done=1 without accepted write, want 0", cyc);
    end
    if (bus.rf_wr_en && !bus.rf_wr_ready && sbq.size() > 0) begin
      chk("stall_addr", bus.rf_wr_addr, sbq[0].addr);
      chk("stall_data", bus.rf_wr_data, sbq[0].data);
    end
  end

  // rst_at < 0: normal op; otherwise rst_n is pulled low for one cycle at that offset from start.
  task automatic run_op(input int a1, input int a2, input int ad, input int stall, input bit pulses,
                        input int rst_at, input bit use_exp, input vreg_t exp_in);
    exp_t e;
    int   last;
    @(posedge clk); #1;
    bus.start    = 1'b1;
    bus.vs1_addr = vaddr_t'(a1);
    bus.vs2_addr = vaddr_t'(a2);
    bus.vd_addr  = vaddr_t'(ad);
    bus.rf_wr_ready = (stall == 0 && rst_at < 0);
    if (rst_at < 0) begin
      e.addr = vaddr_t'(ad);
      e.data = use_exp ? exp_in : ref_vmacc(mem[a1], mem[a2], mem[ad]);
      e.cyc  = cyc + VMACC_LAT + stall;
      sbq.push_back(e);
    end
    last = (rst_at < 0) ? VMACC_LAT + 1 + stall : rst_at + 1;
    for (int k = 1; k <= last; k++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (pulses && (k == 2 || k == VMACC_LAT)) begin
        bus.start    = 1'b1;
        bus.vs1_addr = vaddr_t'($urandom);
        bus.vs2_addr = vaddr_t'($urandom);
        bus.vd_addr  = vaddr_t'($urandom);
      end
      if (rst_at < 0 && k == VMACC_LAT + stall) bus.rf_wr_ready = 1'b1;
      if (k == rst_at) rst_n = 1'b0;
      if (k == rst_at + 1) rst_n = 1'b1;
      @(negedge clk);
      if (k <= 6 && (rst_at < 0 || k < rst_at)) begin
        chk("busy_run", bus.busy, 1);
        chk("rd_en", bus.rf_rd_en, k <= 3);
        chk("mac_valid", bus.mac_valid, k >= 5);
        if (k <= 3) chk("rd_addr", bus.rf_rd_addr, (k == 1) ? a1 : (k == 2) ? a2 : ad);
      end
      if (k == rst_at + 1) begin
        chk("rst_busy", bus.busy, 0);
        chk("rst_wr_en", bus.rf_wr_en, 0);
        chk("rst_mac_valid", bus.mac_valid, 0);
        chk("rst_wr_data", bus.rf_wr_data, 0);
        chk("rst_opnd_a", bus.mac_vector_a, 0);
      end
      if (k == last) begin
        chk("idle_busy", bus.busy, 0);
        chk("pending_writes", sbq.size(), 0);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1);
  end

  initial begin
    vreg_t va, vb, vc, ve;
    int    a1, a2, ad;
    bus.start       = 1'b0;
    bus.vs1_addr    = '0;
    bus.vs2_addr    = '0;
    bus.vd_addr     = '0;
    bus.rf_wr_ready = 1'b0;
    for (int r = 0; r < 32; r++) rand_reg(r);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_rd_en", bus.rf_rd_en, 0);
    chk("reset_wr_en", bus.rf_wr_en, 0);
    chk("reset_mac_valid", bus.mac_valid, 0);
    chk("reset_wr_addr", bus.rf_wr_addr, 0);
    chk("reset_wr_data", bus.rf_wr_data, 0);
    chk("reset_opnd_a", bus.mac_vector_a, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < VL; i++) begin
      va[i*SEW +: SEW] = i + 1;
      vb[i*SEW +: SEW] = 2;
      vc[i*SEW +: SEW] = 100;
      ve[i*SEW +: SEW] = 100 + 2 * (i + 1);
    end
    mem[1] = va; mem[2] = vb; mem[3] = vc;
    run_op(1, 2, 3, 0, 0, -1, 1, ve);
    chk("opnd_a_hold", bus.mac_vector_a, va);
    chk("res_hold", bus.rf_wr_data, ve);

    mem[4] = '0; mem[6] = '0; mem[7] = '0;
    mem[4][31:0] = 32'h0001_0003;
    mem[6][31:0] = 32'h0000_0005;
    mem[7][31:0] = 32'hFFFF_FFFF;
    ve = '0;
    ve[31:0] = 32'h0000_000E;
    run_op(4, 6, 7, 0, 0, -1, 1, ve);

    rand_reg(8); rand_reg(9); rand_reg(10);
    run_op(8, 9, 10, 3, 0, -1, 0, '0);

    rand_reg(11); rand_reg(12); rand_reg(13);
    run_op(11, 12, 13, 0, 1, -1, 0, '0);

    for (int i = 0; i < VL; i++) begin
      mem[5][i*SEW +: SEW] = 32'h10;
      ve[i*SEW +: SEW]     = 32'h110;
    end
    run_op(5, 5, 5, 0, 0, -1, 1, ve);

    run_op(14, 15, 16, 0, 0, 6, 0, '0);
    run_op(17, 18, 19, 0, 0, 8, 0, '0);

    for (int n = 0; n < 24; n++) begin
      a1 = $urandom_range(0, 31);
      a2 = $urandom_range(0, 31);
      ad = $urandom_range(0, 31);
      rand_reg(a1); rand_reg(a2); rand_reg(ad);
      run_op(a1, a2, ad, $urandom_range(0, 3), 0, -1, 0, '0);
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("final_pending", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
